restoring_divider: RTL and testbench
====================================

# restoring_divider

Multi-cycle unsigned restoring divider: the subtract-direction companion to the team's ripple-carry adder datapath. It computes quotient and remainder by one shift-and-trial-subtract per clock, using a (WIDTH+1)-bit subtract and restore on borrow. It sits beside the adder in the arithmetic labs and is driven from switches or keys through a start/done handshake. Results stay on LEDR/HEX until the next operation.

## Interface
- WIDTH, default 4: operand, quotient and remainder width in bits; must be at least 2.
- clock  in  1  rising-edge clock for all state.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request an operation; sampled on the rising edge; accepted only while busy=0.
- dividend  in  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  in  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  out  1  high while state=RUN.
- done  out  1  one-cycle pulse; result outputs are valid from this cycle onward.
- quotient  out  WIDTH  registered quotient; held until the next completion.
- remainder  out  WIDTH  registered remainder; held until the next completion.
- div_by_zero  out  1  registered flag; set with done when the captured divisor was 0.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- Working registers:
  - R: partial remainder, WIDTH+1 bits.
  - Q: shifting dividend/quotient, WIDTH bits.
  - D: divisor, WIDTH bits.
  - cnt: iteration counter, clog2(WIDTH+1) bits.
- IDLE or DONE, start=1, divisor≠0: load R=0, Q=dividend, D=divisor, cnt=WIDTH, then go to RUN.
- IDLE or DONE, start=1, divisor=0: go to DONE directly.
  - Set quotient to all ones, remainder=dividend, div_by_zero=1.
- RUN, each cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}, computed at WIDTH+1 bits.
  - If T[WIDTH]=1 (borrow): R ← {R[WIDTH-1:0], Q[WIDTH-1]} (restore) and Q ← {Q[WIDTH-2:0], 0}.
  - Otherwise: R ← T and Q ← {Q[WIDTH-2:0], 1}.
  - cnt decrements by 1.
- RUN with cnt=1: perform the final iteration, then go to DONE.
  - On that same edge, load quotient with the final Q and remainder with R[WIDTH-1:0] after the final iteration.
  - Clear div_by_zero on that edge.
- DONE lasts exactly one cycle, then returns to IDLE. The only exception is a new start accepted in that cycle, which goes straight to RUN or DONE.
- In RUN, start is ignored. Operand changes during RUN have no effect.
- quotient, remainder and div_by_zero change only on an edge that enters DONE. They never change during RUN.
- Invariant for a nonzero divisor: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - R, Q, D and cnt are all 0.
- Reset is asynchronous at any time, including mid-RUN. The operation is abandoned and all outputs return to their reset values immediately.
- Latency for a nonzero divisor, with the accepting edge as E0:
  - busy=1 after E0 through EWIDTH.
  - done=1 and results are valid after edge E(WIDTH+1)... no: done=1 and results are valid in the cycle after EWIDTH (E0 + WIDTH edges). For WIDTH=4, the results appear 4 edges after acceptance.
- Latency for a zero divisor: done=1 and the results are valid in the cycle right after E0. busy never rises.
- done is high for exactly one cycle per accepted start.
- A back-to-back start sampled during the done cycle is accepted. busy rises on the next cycle, and the previous results stay held until the new completion.
- busy and done are never high simultaneously.

## Test plan
- WIDTH=4, dividend=13, divisor=3, start for 1 cycle:
  - busy is high for 4 cycles.
  - done pulses once, with quotient=4, remainder=1 and div_by_zero=0.
- 15/1 → quotient=15, remainder=0. 5/7 → quotient=0, remainder=5. 15/15 → quotient=1, remainder=0.
- 9/0 → done in the cycle after acceptance, with quotient=15, remainder=9, div_by_zero=1 and busy never high.
  - A following 8/2 then gives quotient=4, remainder=0 and div_by_zero=0.
- 12/5 started, then start held high with 7/2 for the whole RUN:
  - The request is ignored, and the result is quotient=2, remainder=2.
  - Because start is still high in the done cycle, 7/2 is accepted there and gives quotient=3, remainder=1 four cycles later.
- resetn pulsed low during RUN of 14/3 → busy, done, quotient, remainder and div_by_zero all go to 0 asynchronously. No done pulse follows.
- Exhaustive sweep of all 256 dividend/divisor pairs at WIDTH=4 against a reference model, plus a random sweep at WIDTH=8.

Source files
------------

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one shift-and-trial-subtract per clock.
// Results are held on the outputs until the next operation completes.
module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   r_iter;
    logic [WIDTH-1:0] q_iter;

    // One restoring step: a borrow out of the trial subtract keeps the shifted value.
    always_comb begin
        shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = shifted - {1'b0, d_q};
        if (trial[WIDTH]) begin
            r_iter = shifted;
            q_iter = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            r_iter = trial;
            q_iter = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        r_d     = '0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = CW'(WIDTH);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                r_d   = r_iter;
                q_d   = q_iter;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    quot_d  = q_iter;
                    rem_d   = r_iter[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: a WIDTH=4 and a WIDTH=8 instance checked every
// cycle against a transaction-level timing/arithmetic model.
module tb_restoring_divider;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       busy4, done4, dbz4, busy8, done8, dbz8;
    logic [3:0] quot4, rem4;
    logic [7:0] quot8, rem8;

    restoring_divider #(.WIDTH(4)) dut4 (
        .clock(clk), .resetn(resetn), .start(start4), .dividend(a4), .divisor(b4),
        .busy(busy4), .done(done4), .quotient(quot4), .remainder(rem4), .div_by_zero(dbz4)
    );

    restoring_divider #(.WIDTH(8)) dut8 (
        .clock(clk), .resetn(resetn), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(quot8), .remainder(rem8), .div_by_zero(dbz8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an accepted nonzero-divisor op finishes w edges later with a/b, a%b;
    // a zero divisor finishes on the next edge with all-ones and the dividend.
    bit       m_busy[2], m_done[2], m_z[2];
    bit [7:0] m_q[2], m_r[2], pa[2], pb[2];
    int       m_left[2];

    task automatic step(input int i, input int w, input bit st, input bit [7:0] a, input bit [7:0] b);
        if (m_left[i] > 0) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b1;
                m_q[i]    = pa[i] / pb[i];
                m_r[i]    = pa[i] % pb[i];
                m_z[i]    = 1'b0;
            end
        end else begin
            m_done[i] = 1'b0;
            if (st) begin
                if (b != 0) begin
                    m_left[i] = w;
                    m_busy[i] = 1'b1;
                    pa[i]     = a;
                    pb[i]     = b;
                end else begin
                    m_done[i] = 1'b1;
                    m_q[i]    = 8'((1 << w) - 1);
                    m_r[i]    = a;
                    m_z[i]    = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_done[i] = 0; m_z[i] = 0;
                m_q[i] = 0; m_r[i] = 0; m_left[i] = 0;
            end
        end else begin
            step(0, 4, start4, {4'd0, a4}, {4'd0, b4});
            step(1, 8, start8, a8, b8);
        end
    end

    always @(negedge clk) begin
        chk("busy4", busy4, m_busy[0]);
        chk("done4", done4, m_done[0]);
        chk("quot4", quot4, m_q[0]);
        chk("rem4",  rem4,  m_r[0]);
        chk("dbz4",  dbz4,  m_z[0]);
        chk("busy8", busy8, m_busy[1]);
        chk("done8", done8, m_done[1]);
        chk("quot8", quot8, m_q[1]);
        chk("rem8",  rem8,  m_r[1]);
        chk("dbz8",  dbz8,  m_z[1]);
    end

    function automatic bit sel_done(input int inst);
        return (inst != 0) ? done8 : done4;
    endfunction

    function automatic bit sel_busy(input int inst);
        return (inst != 0) ? busy8 : busy4;
    endfunction

    // Called 1 time unit after the accepting edge; returns at the done negedge.
    task automatic wait_done(input int inst, input int exp_lat, input string tag);
        int  busy_cnt = 0;
        int  lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sel_done(inst)) begin
                lat = k;
                break;
            end
            if (sel_busy(inst)) busy_cnt++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    endtask

    task automatic go(input int inst, input int a, input int b);
        int w = (inst != 0) ? 8 : 4;
        @(posedge clk); #1;
        if (inst != 0) begin start8 = 1; a8 = 8'(a); b8 = 8'(b); end
        else begin start4 = 1; a4 = 4'(a); b4 = 4'(b); end
        @(posedge clk); #1;
        start4 = 0; start8 = 0;
        wait_done(inst, (b == 0) ? 0 : w, "op");
        if (inst != 0) $display("op w=8 %0d/%0d -> q=%0d r=%0d z=%0d", a, b, quot8, rem8, dbz8);
        else           $display("op w=4 %0d/%0d -> q=%0d r=%0d z=%0d", a, b, quot4, rem4, dbz4);
    endtask

    task automatic go_lit(input int a, input int b, input int eq, input int er, input int ez);
        go(0, a, b);
        chk("lit_q", quot4, eq);
        chk("lit_r", rem4, er);
        chk("lit_z", dbz4, ez);
        chk("model_q", m_q[0], eq);
        chk("model_r", m_r[0], er);
    endtask

    initial begin
        start4 = 0; start8 = 0; a4 = 0; b4 = 0; a8 = 0; b8 = 0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #21 resetn = 1'b1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_quot", quot4, 0);
        chk("rst_rem",  rem4, 0);
        chk("rst_dbz",  dbz4, 0);

        go_lit(13, 3, 4, 1, 0);
        go_lit(15, 1, 15, 0, 0);
        go_lit(5, 7, 0, 5, 0);
        go_lit(15, 15, 1, 0, 0);
        go_lit(9, 0, 15, 9, 1);
        go_lit(8, 2, 4, 0, 0);

        // 12/5 then start held with 7/2: ignored in RUN, accepted in the done cycle
        @(posedge clk); #1;
        start4 = 1; a4 = 4'd12; b4 = 4'd5;
        @(posedge clk); #1;
        a4 = 4'd7; b4 = 4'd2;
        wait_done(0, 4, "hold_first");
        chk("hold_q1", quot4, 2);
        chk("hold_r1", rem4, 2);
        $display("op w=4 12/5 -> q=%0d r=%0d z=%0d", quot4, rem4, dbz4);
        @(posedge clk); #1;
        start4 = 0;
        chk("hold_keep_q", quot4, 2);
        wait_done(0, 4, "hold_second");
        chk("hold_q2", quot4, 3);
        chk("hold_r2", rem4, 1);
        $display("op w=4 7/2 -> q=%0d r=%0d z=%0d", quot4, rem4, dbz4);

        // asynchronous reset in the middle of 14/3
        @(posedge clk); #1;
        start4 = 1; a4 = 4'd14; b4 = 4'd3;
        @(posedge clk); #1;
        start4 = 0;
        @(negedge clk); @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_busy", busy4, 0);
        chk("arst_done", done4, 0);
        chk("arst_quot", quot4, 0);
        chk("arst_rem",  rem4, 0);
        chk("arst_dbz",  dbz4, 0);
        @(negedge clk); #2 resetn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("arst_no_done", done4, 0);
        end
        $display("op w=4 14/3 abandoned by reset");

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                go(0, a, b);

        for (int n = 0; n < 60; n++)
            go(1, int'($urandom_range(0, 255)), (n % 15 == 0) ? 0 : int'($urandom_range(0, 255)));
        go(1, 200, 7);
        chk("w8_q", quot8, 28);
        chk("w8_r", rem8, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
